// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-requester SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int ARB_ADDR_W = 24;
    localparam int ARB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of 1-bit requester tags for outstanding reads.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             push,
    input  req_id_t          push_tag,
    input  logic             pop,
    output req_id_t          head_tag,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    req_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_tag = mem[rd_ptr];

    always_ff @(posedge clk_50) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between two requesters.
// Define SDRAM_ARB_PERF_EN to add saturating grant/stall performance counters.
//
// state | meaning
// IDLE  | no grant; picks a requester for next cycle (ties go to !rr_last)
// GNT0  | requester 0 owns the controller port
// GNT1  | requester 1 owns the controller port
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int MAX_HOLD    = 8,
    parameter int MAX_PENDING = 8
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [1:0]        m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [1:0]        m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [1:0]        s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
`ifdef SDRAM_ARB_PERF_EN
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_stall,
`endif
    output logic              err_unexp_rdv
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int CNT_W  = $clog2(MAX_PENDING) + 1;

    arb_state_t        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    req_id_t           rr_last, rr_nxt;

    logic       req0, req1, sel1;
    logic       gnt_read, gnt_write, gnt_req, other_req, accept;
    logic       fifo_full, fifo_empty, fifo_pop;
    req_id_t    head_tag;
    logic [CNT_W-1:0] fifo_count;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    assign sel1 = (state == GNT1);

    // Command path is purely combinational so a grant adds no latency.
    assign s_address    = sel1 ? m1_address    : m0_address;
    assign s_writedata  = sel1 ? m1_writedata  : m0_writedata;
    assign s_byteenable = sel1 ? m1_byteenable : m0_byteenable;

    assign gnt_read  = (state == GNT0) ? m0_read  : (state == GNT1) ? m1_read  : 1'b0;
    assign gnt_write = (state == GNT0) ? m0_write : (state == GNT1) ? m1_write : 1'b0;
    assign gnt_req   = gnt_read | gnt_write;
    assign other_req = sel1 ? req0 : req1;

    // A read is withheld from the controller while the tag FIFO is full.
    assign s_read  = gnt_read & ~fifo_full;
    assign s_write = gnt_write;
    assign accept  = gnt_req & ~s_waitrequest & ~(gnt_read & fifo_full);

    assign m0_waitrequest = ~(accept & (state == GNT0));
    assign m1_waitrequest = ~(accept & (state == GNT1));

    assign fifo_pop         = s_readdatavalid & ~fifo_empty;
    assign m0_readdatavalid = fifo_pop & (head_tag == 1'b0);
    assign m1_readdatavalid = fifo_pop & (head_tag == 1'b1);
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    sdram_arb_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
        .clk_50   (clk_50),
        .reset    (reset),
        .push     (accept & gnt_read),
        .push_tag (sel1),
        .pop      (fifo_pop),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        rr_nxt    = rr_last;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || rr_last)) state_nxt = GNT0;
                else if (req1)                  state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (!gnt_req || (accept && hold_cnt == HOLD_W'(MAX_HOLD - 1))) begin
                    state_nxt = other_req ? (sel1 ? GNT0 : GNT1) : IDLE;
                    hold_nxt  = '0;
                    rr_nxt    = sel1;
                end else if (accept) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rr_last  <= 1'b1;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            rr_last  <= rr_nxt;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset)                                          err_unexp_rdv <= 1'b0;
        else if (s_readdatavalid && fifo_count == '0)       err_unexp_rdv <= 1'b1;
    end

`ifdef SDRAM_ARB_PERF_EN
    always_ff @(posedge clk_50) begin
        if (reset) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept && !sel1)                perf_grant0 <= sat_inc(perf_grant0);
            if (accept && sel1)                 perf_grant1 <= sat_inc(perf_grant1);
            if (state != IDLE && other_req)     perf_stall  <= sat_inc(perf_stall);
        end
    end
`endif

endmodule
